// File: rtl/mips_loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader.
// Contents:
//   state_t            loader FSM states
//   MAGIC_DEFAULT      default header magic (header bits [31:16])
//   MAGIC_HI/LO        header magic field position
//   COUNT_HI/LO        header word-count field position
//   hdr_magic()        extract the magic field from a header word
//   hdr_count()        extract the word-count field from a header word
package mips_loader_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_HDR = 3'd1,
    LOAD     = 3'd2,
    HOLD     = 3'd3,
    RUN      = 3'd4,
    ERROR    = 3'd5
  } state_t;

  localparam logic [15:0] MAGIC_DEFAULT = 16'h4D49;

  localparam int unsigned MAGIC_HI = 31;
  localparam int unsigned MAGIC_LO = 16;
  localparam int unsigned COUNT_HI = 15;
  localparam int unsigned COUNT_LO = 0;

  function automatic logic [15:0] hdr_magic(input logic [31:0] w);
    return w[MAGIC_HI:MAGIC_LO];
  endfunction

  function automatic logic [15:0] hdr_count(input logic [31:0] w);
    return w[COUNT_HI:COUNT_LO];
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Boot-time program loader for the single-cycle MIPS instruction memory.
// Accepts a header word (magic + word count) followed by the program words
// on a valid/ready stream, writes each word through the instruction memory
// write port one cycle after its handshake, and keeps the core in reset until
// the image is complete plus HOLD_CYCLES cycles.
// Ports:
//   clk           clock, rising edge
//   reset         asynchronous, active-high reset
//   reload        one-cycle pulse: abort and wait for a new header
//   in_valid      stream word valid
//   in_data       stream word
//   in_ready      loader accepts a word this cycle
//   imem_we       instruction memory write strobe
//   imem_addr     instruction memory word index
//   imem_wdata    instruction memory write data
//   cpu_reset     reset to the MIPS core
//   done          load complete, core running
//   error         bad header received
//   words_loaded  words written since the last header
module imem_loader
  import mips_loader_pkg::*;
#(
  parameter int          ADDR_W      = 8,
  parameter logic [15:0] MAGIC       = MAGIC_DEFAULT,
  parameter int          HOLD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reload,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  // Hold counter runs 0 .. HOLD_CYCLES-1.
  localparam int HOLD_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES);
  localparam logic [16:0] DEPTH = 17'(1 << ADDR_W);

  state_t              state_q,  state_d;
  logic [ADDR_W-1:0]   index_q,  index_d;
  logic [ADDR_W:0]     words_q,  words_d;
  logic [ADDR_W:0]     remain_q, remain_d;
  logic [HOLD_W-1:0]   hold_q,   hold_d;
  logic                we_q,     we_d;
  logic [ADDR_W-1:0]   addr_q,   addr_d;
  logic [31:0]         wdata_q,  wdata_d;

  logic                xfer;
  logic [16:0]         hdr_cnt;

  // Status outputs are pure decodes of the registered state.
  assign in_ready     = (state_q == WAIT_HDR) || (state_q == LOAD);
  assign cpu_reset    = (state_q != RUN);
  assign done         = (state_q == RUN);
  assign error        = (state_q == ERROR);
  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign words_loaded = words_q;

  assign xfer    = in_valid && in_ready;
  assign hdr_cnt = {1'b0, hdr_count(in_data)};

  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    words_d  = words_q;
    remain_d = remain_q;
    hold_d   = hold_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;

    // reload takes priority over any transfer in the same cycle, so a word
    // offered alongside it is dropped without a write.
    if (reload) begin
      state_d  = WAIT_HDR;
      index_d  = '0;
      words_d  = '0;
      remain_d = '0;
      hold_d   = '0;
    end else begin
      case (state_q)
        IDLE: state_d = WAIT_HDR;

        WAIT_HDR: begin
          if (xfer) begin
            index_d = '0;
            words_d = '0;
            hold_d  = '0;
            if (hdr_magic(in_data) != MAGIC) begin
              state_d = ERROR;
            end else if (hdr_cnt == 17'd0) begin
              state_d = HOLD;
            end else if (hdr_cnt > DEPTH) begin
              state_d = ERROR;
            end else begin
              state_d  = LOAD;
              remain_d = (ADDR_W+1)'(hdr_cnt);
            end
          end
        end

        LOAD: begin
          if (xfer) begin
            we_d     = 1'b1;
            addr_d   = index_q;
            wdata_d  = in_data;
            index_d  = index_q + ADDR_W'(1);
            words_d  = words_q + (ADDR_W+1)'(1);
            remain_d = remain_q - (ADDR_W+1)'(1);
            if (remain_q == (ADDR_W+1)'(1)) begin
              state_d = HOLD;
              hold_d  = '0;
            end
          end
        end

        // HOLD is entered on the last handshake edge; leaving after
        // HOLD_CYCLES-1 further edges lands the RUN transition exactly
        // HOLD_CYCLES edges after that handshake.
        HOLD: begin
          if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
            state_d = RUN;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end

        RUN:     state_d = RUN;
        ERROR:   state_d = ERROR;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      index_q  <= '0;
      words_q  <= '0;
      remain_q <= '0;
      hold_q   <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      words_q  <= words_d;
      remain_q <= remain_d;
      hold_q   <= hold_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        clk;
  logic        reset;
  logic        reload;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;
  logic [8:0]  words_loaded;

  imem_loader #(
    .ADDR_W      (8),
    .MAGIC       (16'h4D49),
    .HOLD_CYCLES (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .reload       (reload),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_reset    (cpu_reset),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instruction memory model fed by the write port, sampled mid-cycle.
  logic [31:0] mem [256];
  int wr_count = 0;
  int zero_wr  = 0;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      mem[imem_addr] = imem_wdata;
      wr_count++;
      if (imem_addr == 8'd0) zero_wr++;
    end
  end

  typedef struct {
    logic        rl;
    logic        v;
    logic [31:0] d;
    logic        rdy;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wd;
    logic        cr;
    logic        dn;
    logic        er;
    logic [8:0]  wl;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic rl, input logic v, input logic [31:0] d,
                              input logic rdy, input logic we, input logic [7:0] addr,
                              input logic [31:0] wd, input logic cr, input logic dn,
                              input logic er, input logic [8:0] wl);
    vec_t r;
    r.rl = rl; r.v = v; r.d = d; r.rdy = rdy; r.we = we; r.addr = addr;
    r.wd = wd; r.cr = cr; r.dn = dn; r.er = er; r.wl = wl;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic rl, input logic v, input logic [31:0] d);
    reload   = rl;
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] H2   = 32'h4D490002;
  localparam logic [31:0] ADDI = 32'h00641020;
  localparam logic [31:0] SUBI = 32'h00651822;
  localparam logic [31:0] X    = 32'hDEADBEEF;
  localparam logic [31:0] A5   = 32'hAAAA5555;
  localparam logic [31:0] W1   = 32'h11111111;

  initial begin
    int snap;
    int errs;

    reset = 1'b1; reload = 1'b0; in_valid = 1'b0; in_data = '0;

    //        rl v  d             rdy we addr  wd    cr dn er wl
    // basic load, in_valid held high (offered already while IDLE)
    vq.push_back(mk(0, 1, H2,           1, 0, 8'd0, 32'h0, 1, 0, 0, 9'd0));
    vq.push_back(mk(0, 1, H2,           1, 0, 8'd0, 32'h0, 1, 0, 0, 9'd0));
    vq.push_back(mk(0, 1, ADDI,         1, 1, 8'd0, ADDI,  1, 0, 0, 9'd1));
    vq.push_back(mk(0, 1, SUBI,         0, 1, 8'd1, SUBI,  1, 0, 0, 9'd2));
    vq.push_back(mk(0, 1, X,            0, 0, 8'd1, SUBI,  1, 0, 0, 9'd2));
    vq.push_back(mk(0, 0, X,            0, 0, 8'd1, SUBI,  0, 1, 0, 9'd2));
    vq.push_back(mk(0, 0, X,            0, 0, 8'd1, SUBI,  0, 1, 0, 9'd2));
    // reload from RUN, then same image with 3 bubble cycles between words
    vq.push_back(mk(1, 0, X,            1, 0, 8'd1, SUBI,  1, 0, 0, 9'd0));
    vq.push_back(mk(0, 1, H2,           1, 0, 8'd1, SUBI,  1, 0, 0, 9'd0));
    vq.push_back(mk(0, 1, ADDI,         1, 1, 8'd0, ADDI,  1, 0, 0, 9'd1));
    vq.push_back(mk(0, 0, 32'hFFFFFFFF, 1, 0, 8'd0, ADDI,  1, 0, 0, 9'd1));
    vq.push_back(mk(0, 0, 32'hFFFFFFFF, 1, 0, 8'd0, ADDI,  1, 0, 0, 9'd1));
    vq.push_back(mk(0, 0, 32'hFFFFFFFF, 1, 0, 8'd0, ADDI,  1, 0, 0, 9'd1));
    vq.push_back(mk(0, 1, SUBI,         0, 1, 8'd1, SUBI,  1, 0, 0, 9'd2));
    vq.push_back(mk(0, 0, X,            0, 0, 8'd1, SUBI,  1, 0, 0, 9'd2));
    vq.push_back(mk(0, 0, X,            0, 0, 8'd1, SUBI,  0, 1, 0, 9'd2));
    // bad magic, stuck in ERROR until reload, then a 1-word load
    vq.push_back(mk(1, 0, X,            1, 0, 8'd1, SUBI,  1, 0, 0, 9'd0));
    vq.push_back(mk(0, 1, 32'h12340001, 0, 0, 8'd1, SUBI,  1, 0, 1, 9'd0));
    vq.push_back(mk(0, 1, 32'h4D490001, 0, 0, 8'd1, SUBI,  1, 0, 1, 9'd0));
    vq.push_back(mk(1, 0, X,            1, 0, 8'd1, SUBI,  1, 0, 0, 9'd0));
    vq.push_back(mk(0, 1, 32'h4D490001, 1, 0, 8'd1, SUBI,  1, 0, 0, 9'd0));
    vq.push_back(mk(0, 1, A5,           0, 1, 8'd0, A5,    1, 0, 0, 9'd1));
    vq.push_back(mk(0, 0, X,            0, 0, 8'd0, A5,    1, 0, 0, 9'd1));
    vq.push_back(mk(0, 0, X,            0, 0, 8'd0, A5,    0, 1, 0, 9'd1));
    // count 257 is too large
    vq.push_back(mk(1, 0, X,            1, 0, 8'd0, A5,    1, 0, 0, 9'd0));
    vq.push_back(mk(0, 1, 32'h4D490101, 0, 0, 8'd0, A5,    1, 0, 1, 9'd0));
    // count 0: no writes, RUN two edges after the header
    vq.push_back(mk(1, 0, X,            1, 0, 8'd0, A5,    1, 0, 0, 9'd0));
    vq.push_back(mk(0, 1, 32'h4D490000, 0, 0, 8'd0, A5,    1, 0, 0, 9'd0));
    vq.push_back(mk(0, 0, X,            0, 0, 8'd0, A5,    1, 0, 0, 9'd0));
    vq.push_back(mk(0, 0, X,            0, 0, 8'd0, A5,    0, 1, 0, 9'd0));
    // reload coincident with the 2nd word of a 4-word load
    vq.push_back(mk(1, 0, X,            1, 0, 8'd0, A5,    1, 0, 0, 9'd0));
    vq.push_back(mk(0, 1, 32'h4D490004, 1, 0, 8'd0, A5,    1, 0, 0, 9'd0));
    vq.push_back(mk(0, 1, W1,           1, 1, 8'd0, W1,    1, 0, 0, 9'd1));
    vq.push_back(mk(1, 1, 32'h22222222, 1, 0, 8'd0, W1,    1, 0, 0, 9'd0));
    vq.push_back(mk(0, 0, X,            1, 0, 8'd0, W1,    1, 0, 0, 9'd0));

    // reset values while reset is held
    @(posedge clk);
    #1;
    chk("rst.in_ready", in_ready,     1'b0);
    chk("rst.we",       imem_we,      1'b0);
    chk("rst.addr",     imem_addr,    8'd0);
    chk("rst.wdata",    imem_wdata,   32'd0);
    chk("rst.cpu_reset",cpu_reset,    1'b1);
    chk("rst.done",     done,         1'b0);
    chk("rst.error",    error,        1'b0);
    chk("rst.words",    words_loaded, 9'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vq[i]) begin
      step(vq[i].rl, vq[i].v, vq[i].d);
      chk($sformatf("v%0d.rdy",   i), in_ready,     vq[i].rdy);
      chk($sformatf("v%0d.we",    i), imem_we,      vq[i].we);
      chk($sformatf("v%0d.addr",  i), imem_addr,    vq[i].addr);
      chk($sformatf("v%0d.wdata", i), imem_wdata,   vq[i].wd);
      chk($sformatf("v%0d.cpurst",i), cpu_reset,    vq[i].cr);
      chk($sformatf("v%0d.done",  i), done,         vq[i].dn);
      chk($sformatf("v%0d.err",   i), error,        vq[i].er);
      chk($sformatf("v%0d.words", i), words_loaded, vq[i].wl);
    end
    @(negedge clk);
    chk("tbl.wr_count", wr_count, 6);
    chk("tbl.mem0",     mem[0],   W1);
    chk("tbl.mem1",     mem[1],   SUBI);

    // full-depth image: 256 words, last write at 255, no wrap to 0
    snap    = wr_count;
    zero_wr = 0;
    step(1'b1, 1'b0, X);
    step(1'b0, 1'b1, 32'h4D490100);
    chk("f256.hdr_rdy", in_ready, 1'b1);
    chk("f256.hdr_err", error,    1'b0);
    for (int i = 0; i < 256; i++) begin
      step(1'b0, 1'b1, 32'hC0DE0000 | 32'(i));
      if (i == 254) chk("f256.rdy254", in_ready, 1'b1);
    end
    chk("f256.rdy_last",  in_ready,     1'b0);
    chk("f256.addr_last", imem_addr,    8'd255);
    chk("f256.words",     words_loaded, 9'd256);
    step(1'b0, 1'b1, X);
    chk("f256.we_after",  imem_we,   1'b0);
    chk("f256.cr_hold",   cpu_reset, 1'b1);
    step(1'b0, 1'b0, X);
    chk("f256.done",      done,      1'b1);
    chk("f256.cr_run",    cpu_reset, 1'b0);
    @(negedge clk);
    chk("f256.wr_count",  wr_count - snap, 256);
    chk("f256.zero_wr",   zero_wr, 1);
    errs = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== (32'hC0DE0000 | 32'(i))) errs++;
    chk("f256.mem", errs, 0);

    // async reset while a write strobe is pending
    step(1'b1, 1'b0, X);
    step(1'b0, 1'b1, 32'h4D490004);
    step(1'b0, 1'b1, 32'h55550000);
    step(1'b0, 1'b1, 32'h55550001);
    snap = wr_count;
    chk("ares.we_pending", imem_we,   1'b1);
    chk("ares.addr_pend",  imem_addr, 8'd1);
    #1 reset = 1'b1;
    #1;
    chk("ares.in_ready", in_ready,     1'b0);
    chk("ares.we",       imem_we,      1'b0);
    chk("ares.addr",     imem_addr,    8'd0);
    chk("ares.wdata",    imem_wdata,   32'd0);
    chk("ares.cpu_reset",cpu_reset,    1'b1);
    chk("ares.done",     done,         1'b0);
    chk("ares.error",    error,        1'b0);
    chk("ares.words",    words_loaded, 9'd0);
    @(negedge clk);
    #1;
    chk("ares.no_write", wr_count, snap);
    reset = 1'b0;
    in_valid = 1'b0;
    reload = 1'b0;
    @(posedge clk);
    #1;
    chk("ares.wait_rdy", in_ready,  1'b1);
    chk("ares.wait_cr",  cpu_reset, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader that streams a program image into the single-cycle MIPS instruction memory through its write port.
- Holds the core in reset until the whole image has been written.
- Lets benches and board bring-up load programs through a real port, replacing hierarchical pokes into the instruction memory array.
- Sits between a word-stream source (UART bridge or TB driver) and the instruction memory write port plus the core reset.

Parameters:
- ADDR_W, 8, instruction memory word-address width; depth is 2**ADDR_W words; legal range 1..16.
- MAGIC, 16'h4D49, required value of header bits [31:16].
- HOLD_CYCLES, 2, cycles cpu_reset stays high after the last handshake; must be >= 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- reload  in  1  one-cycle pulse; aborts the current activity and restarts header wait.
- in_valid  in  1  stream word valid.
- in_data  in  32  stream word.
- in_ready  out  1  loader accepts a word this cycle.
- imem_we  out  1  instruction memory write strobe.
- imem_addr  out  ADDR_W  word index, not byte address.
- imem_wdata  out  32  write data.
- cpu_reset  out  1  reset to the MIPS core.
- done  out  1  load complete; core running.
- error  out  1  bad header.
- words_loaded  out  ADDR_W+1  words written since the last header.

Behaviour:
- Clock and reset: single clock clk. reset is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, done=0, error=0, words_loaded=0, index=0.
- All outputs are registered or are decodes of registered state.
- Handshake: a transfer occurs on a rising edge where in_valid && in_ready. in_ready=1 only in WAIT_HDR and LOAD. in_data is ignored when there is no transfer.
- IDLE: moves to WAIT_HDR unconditionally on the next edge, so in_ready is never high during or immediately out of reset.
- WAIT_HDR: on a transfer, decode count = in_data[15:0].
  - in_data[31:16] != MAGIC -> ERROR.
  - count == 0 -> HOLD.
  - count > 2**ADDR_W (compared at 17 bits) -> ERROR.
  - otherwise -> LOAD, with remaining=count and index=0.
- LOAD, per transfer:
  - On the next cycle: imem_we=1 for exactly one cycle, imem_addr=index, imem_wdata=the transferred word.
  - index and words_loaded increment; remaining decrements.
  - Write latency is 1 cycle from handshake edge to strobe.
- LOAD, last word: the transfer with remaining==1 moves to HOLD, so in_ready drops the following cycle. Address never wraps; count == 2**ADDR_W ends with a write to address 2**ADDR_W-1.
- Idle stream: cycles with no transfer produce no write and no state change.
- HOLD:
  - cpu_reset=1; count HOLD_CYCLES cycles, then -> RUN.
  - The final imem write therefore completes before cpu_reset falls.
  - cpu_reset falls exactly HOLD_CYCLES cycles after the last handshake edge (header edge if count==0).
- RUN: cpu_reset=0, done=1, in_ready=0. reload -> WAIT_HDR with cpu_reset=1, done=0, index=0, words_loaded=0.
- ERROR: error=1, cpu_reset=1, in_ready=0, no writes. Exits only on reload (-> WAIT_HDR, error=0) or reset.
- reload in WAIT_HDR, LOAD or HOLD: abort to WAIT_HDR, clear index and words_loaded, cpu_reset stays 1. Already-written words are left in memory.
- reload coinciding with a transfer: reload wins; the word is dropped and no write is issued for it.
- Asynchronous reset mid-LOAD: immediate return to reset values; any pending write strobe is cancelled.

Decomposition:
- Shared package mips_loader_pkg: state enum (IDLE, WAIT_HDR, LOAD, HOLD, RUN, ERROR), default MAGIC constant, header field positions (MAGIC [31:16], COUNT [15:0]).
- Single module; no sub-module needed. The write-strobe register stage stays inline.

Test Plan:
- Basic load: header 32'h4D490002, then ADD 32'h00641020 and SUB 32'h00651822, in_valid held high.
  -> Writes at addr 0 and 1, each one cycle after its handshake.
  -> cpu_reset falls 2 cycles after the second handshake; done=1; words_loaded=2.
  -> Core then executes both instructions from PC 0.
- Bubbles: same image with in_valid low for 3 cycles between words.
  -> No extra strobes; addresses are still 0 and 1; no change in data.
- Bad magic: 32'h12340001.
  -> error=1, in_ready=0, zero writes, cpu_reset=1.
  -> reload pulse then a valid header gives error=0 and a normal load.
- Size bounds, ADDR_W=8:
  -> count 257 -> ERROR.
  -> count 0 -> no writes; done after HOLD_CYCLES.
  -> count 256 -> last write at addr 255; no write to addr 0 after the first.
- Abort and reset: reload coincident with the 2nd data word of a 4-word load -> that word is not written; state WAIT_HDR; words_loaded=0.
- Reset mid-LOAD: async reset asserted mid-LOAD -> all outputs at reset values within the same cycle.
